// File: rtl/bitcoin_miner_axil_slave.sv
// bitcoin_miner_axil_slave
// AXI4-Lite register front end of the bitcoin miner IP. Holds the job
// configuration (nonce range, target, midstate, header tail), issues
// start/abort pulses to the hash core and reports core status and the
// winning nonce back to the host.
//
// Ports:
//   ACLK, ARESETN          clock, async active-low reset
//   AW*/W*/B*              AXI4-Lite write channels (AWPROT ignored)
//   AR*/R*                 AXI4-Lite read channels  (ARPROT ignored)
//   miner_start/abort      one-cycle pulses to the core
//   nonce_start/end, target_zeros, midstate, header_tail   job config
//   miner_busy/found/done, found_nonce_in                  core status
module bitcoin_miner_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic                            miner_start,
  output logic                            miner_abort,
  output logic [31:0]                     nonce_start,
  output logic [31:0]                     nonce_end,
  output logic [7:0]                      target_zeros,
  output logic [255:0]                    midstate,
  output logic [95:0]                     header_tail,
  input  logic                            miner_busy,
  input  logic                            miner_found,
  input  logic [31:0]                     found_nonce_in,
  input  logic                            miner_done
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = dat[8*i +: 8];
    return r;
  endfunction

  // Readies are held off until the first edge after reset release.
  logic              rdy_en_q;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [4:0]        aw_addr_q, aw_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       nonce_start_q, nonce_start_d, nonce_end_q, nonce_end_d;
  logic [7:0]        target_q, target_d;
  logic [31:0]       scratch_q, scratch_d, found_nonce_q, found_nonce_d;
  logic              found_q, found_d, done_q, done_d;
  logic              start_q, start_d, abort_q, abort_d;
  logic [7:0][31:0]  midstate_q, midstate_d;
  logic [2:0][31:0]  tail_q, tail_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [4:0]        wr_idx, rd_idx;
  logic [31:0]       wr_data, rd_val;
  logic [3:0]        wr_strb;
  logic              rd_err;
  logic              unused_bits;

  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = rdy_en_q & ~aw_held_q & ~bvalid_q;
  assign WREADY  = rdy_en_q & ~w_held_q & ~bvalid_q;
  assign ARREADY = rdy_en_q & ~rvalid_q;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign ar_hs   = ARVALID & ARREADY;
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_idx  = aw_held_q ? aw_addr_q : AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held_q ? w_data_q : WDATA;
  assign wr_strb = w_held_q ? w_strb_q : WSTRB;
  assign rd_idx  = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign BVALID       = bvalid_q;
  assign BRESP        = bresp_q;
  assign RVALID       = rvalid_q;
  assign RRESP        = rresp_q;
  assign RDATA        = rdata_q;
  assign miner_start  = start_q;
  assign miner_abort  = abort_q;
  assign nonce_start  = nonce_start_q;
  assign nonce_end    = nonce_end_q;
  assign target_zeros = target_q;
  assign midstate     = midstate_q;
  assign header_tail  = tail_q;

  // Read decode from pre-edge register state.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx) inside
      5'd0:           rd_val = nonce_start_q;
      5'd1:           rd_val = nonce_end_q;
      5'd2:           rd_val = {24'd0, target_q};
      5'd3:           rd_val = scratch_q;
      5'd4:           rd_val = '0;
      5'd5:           rd_val = {29'd0, done_q, found_q, miner_busy};
      5'd6:           rd_val = found_nonce_q;
      [5'd8:5'd15]:   rd_val = midstate_q[rd_idx[2:0]];
      [5'd16:5'd18]:  rd_val = tail_q[rd_idx[1:0]];
      default:        rd_err = 1'b1;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q; aw_addr_d = aw_addr_q;
    w_held_d = w_held_q; w_data_d = w_data_q; w_strb_d = w_strb_q;
    bvalid_d = bvalid_q; bresp_d = bresp_q;
    rvalid_d = rvalid_q; rresp_d = rresp_q; rdata_d = rdata_q;
    nonce_start_d = nonce_start_q; nonce_end_d = nonce_end_q;
    target_d = target_q; scratch_d = scratch_q; found_nonce_d = found_nonce_q;
    found_d = found_q; done_d = done_q;
    midstate_d = midstate_q; tail_d = tail_q;
    start_d = 1'b0; abort_d = 1'b0;

    if (bvalid_q && BREADY) bvalid_d = 1'b0;
    if (aw_hs) begin aw_held_d = 1'b1; aw_addr_d = AWADDR[C_S_AXI_ADDR_WIDTH-1:2]; end
    if (w_hs)  begin w_held_d = 1'b1; w_data_d = WDATA; w_strb_d = WSTRB; end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = OKAY;
      case (wr_idx) inside
        5'd0: if (miner_busy) bresp_d = SLVERR;
              else nonce_start_d = merge(nonce_start_q, wr_data, wr_strb);
        5'd1: if (miner_busy) bresp_d = SLVERR;
              else nonce_end_d = merge(nonce_end_q, wr_data, wr_strb);
        5'd2: if (miner_busy) bresp_d = SLVERR;
              else if (wr_strb[0]) target_d = wr_data[7:0];
        5'd3: scratch_d = merge(scratch_q, wr_data, wr_strb);
        5'd4: if (wr_strb[0]) begin
                // ABORT takes priority when both bits are set.
                if (wr_data[1])                    abort_d = 1'b1;
                else if (wr_data[0] && !miner_busy) start_d = 1'b1;
              end
        5'd5: if (wr_strb[0]) begin
                if (wr_data[1]) found_d = 1'b0;
                if (wr_data[2]) done_d  = 1'b0;
              end
        [5'd8:5'd15]: if (miner_busy) bresp_d = SLVERR;
              else midstate_d[wr_idx[2:0]] = merge(midstate_q[wr_idx[2:0]], wr_data, wr_strb);
        [5'd16:5'd18]: if (miner_busy) bresp_d = SLVERR;
              else tail_d[wr_idx[1:0]] = merge(tail_q[wr_idx[1:0]], wr_data, wr_strb);
        default: bresp_d = SLVERR;  // unmapped or read-only
      endcase
    end

    // Core events land after any W1C so a same-cycle set wins.
    if (miner_found) begin found_d = 1'b1; found_nonce_d = found_nonce_in; end
    if (miner_done)  done_d = 1'b1;

    if (rvalid_q && RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_err ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en_q <= 1'b0;
      aw_held_q <= 1'b0; aw_addr_q <= '0;
      w_held_q <= 1'b0; w_data_q <= '0; w_strb_q <= '0;
      bvalid_q <= 1'b0; bresp_q <= '0;
      rvalid_q <= 1'b0; rresp_q <= '0; rdata_q <= '0;
      nonce_start_q <= '0; nonce_end_q <= '0; target_q <= '0;
      scratch_q <= '0; found_nonce_q <= '0; found_q <= 1'b0; done_q <= 1'b0;
      midstate_q <= '0; tail_q <= '0;
      start_q <= 1'b0; abort_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      aw_held_q <= aw_held_d; aw_addr_q <= aw_addr_d;
      w_held_q <= w_held_d; w_data_q <= w_data_d; w_strb_q <= w_strb_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d;
      rvalid_q <= rvalid_d; rresp_q <= rresp_d; rdata_q <= rdata_d;
      nonce_start_q <= nonce_start_d; nonce_end_q <= nonce_end_d; target_q <= target_d;
      scratch_q <= scratch_d; found_nonce_q <= found_nonce_d;
      found_q <= found_d; done_q <= done_d;
      midstate_q <= midstate_d; tail_q <= tail_d;
      start_q <= start_d; abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_bitcoin_miner_axil_slave.sv
// Directed bench for bitcoin_miner_axil_slave: register access, byte strobes,
// control pulses, busy protection, sticky status, error responses and reset.
module tb_bitcoin_miner_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [6:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        miner_start, miner_abort, miner_busy, miner_found, miner_done;
  logic [31:0] nonce_start, nonce_end, found_nonce_in;
  logic [7:0]  target_zeros;
  logic [255:0] midstate;
  logic [95:0] header_tail;

  int npass = 0, ntotal = 0;
  int start_cnt = 0, abort_cnt = 0;
  logic [31:0] rd;
  logic [1:0]  rsp;

  bitcoin_miner_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .miner_start(miner_start), .miner_abort(miner_abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target_zeros(target_zeros),
    .midstate(midstate), .header_tail(header_tail),
    .miner_busy(miner_busy), .miner_found(miner_found),
    .found_nonce_in(found_nonce_in), .miner_done(miner_done)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (miner_start) start_cnt++;
    if (miner_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the B handshake.
  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, b_ok = 0, af, wf;
    int cnt = 0;
    AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1; BREADY = 1;
    while (!(aw_ok && w_ok) && cnt < 20) begin
      @(negedge ACLK); af = AWVALID && AWREADY; wf = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (af) begin aw_ok = 1; AWVALID = 0; end
      if (wf) begin w_ok = 1; WVALID = 0; end
      cnt++;
    end
    resp = 2'bxx; cnt = 0;
    while (!b_ok && cnt < 20) begin
      @(negedge ACLK);
      if (BVALID) begin b_ok = 1; resp = BRESP; end
      @(posedge ACLK); #1;
      cnt++;
    end
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_ok = 0, r_ok = 0, af;
    int cnt = 0;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    while (!ar_ok && cnt < 20) begin
      @(negedge ACLK); af = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (af) begin ar_ok = 1; ARVALID = 0; end
      cnt++;
    end
    d = 'x; resp = 2'bxx; cnt = 0;
    while (!r_ok && cnt < 20) begin
      @(negedge ACLK);
      if (RVALID) begin r_ok = 1; d = RDATA; resp = RRESP; end
      @(posedge ACLK); #1;
      cnt++;
    end
    ARVALID = 0;
  endtask

  initial begin
    ARESETN = 0; AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    WDATA = 0; WSTRB = 0; miner_busy = 0; miner_found = 0; miner_done = 0;
    found_nonce_in = 0;
    #12;
    check("rst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    check("rst_valids", {30'd0, BVALID, RVALID}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    @(posedge ACLK); #1 ARESETN = 1;
    check("ready_before_edge", {31'd0, AWREADY}, 32'd0);
    @(posedge ACLK); #1;
    check("ready_after_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

    // Basic RW registers
    axi_write(7'h00, 32'h1, 4'hF, rsp); check("wr00_resp", rsp, 0);
    axi_write(7'h04, 32'h2, 4'hF, rsp); check("wr04_resp", rsp, 0);
    axi_write(7'h08, 32'h3, 4'hF, rsp); check("wr08_resp", rsp, 0);
    axi_write(7'h0C, 32'h4, 4'hF, rsp); check("wr0c_resp", rsp, 0);
    axi_read(7'h00, rd, rsp); check("rd00", rd, 32'h1); check("rd00_resp", rsp, 0);
    axi_read(7'h04, rd, rsp); check("rd04", rd, 32'h2);
    axi_read(7'h08, rd, rsp); check("rd08", rd, 32'h3);
    axi_read(7'h0C, rd, rsp); check("rd0c", rd, 32'h4); check("rd0c_resp", rsp, 0);
    check("nonce_end_out", nonce_end, 32'h2);
    axi_write(7'h08, 32'hFFFF_FFFF, 4'hF, rsp);
    axi_read(7'h08, rd, rsp); check("target_mask", rd, 32'h0000_00FF);
    axi_read(7'h10, rd, rsp); check("ctrl_reads0", rd, 32'h0);

    // W leads AW by 3 cycles, partial strobe
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'b0011; WVALID = 1; BREADY = 1;
    @(posedge ACLK); #1 WVALID = 0;
    repeat (3) @(posedge ACLK);
    #1 AWADDR = 7'h20; AWVALID = 1;
    @(negedge ACLK);
    check("wfirst_no_b", {31'd0, BVALID}, 0);
    check("wfirst_wready_low", {31'd0, WREADY}, 0);
    @(posedge ACLK); #1 AWVALID = 0;
    @(negedge ACLK);
    check("wfirst_b", {31'd0, BVALID}, 1); check("wfirst_bresp", BRESP, 0);
    @(posedge ACLK); #1;
    @(negedge ACLK); check("wfirst_b_once", {31'd0, BVALID}, 0);
    check("midstate0", midstate[31:0], 32'h0000_BEEF);
    @(posedge ACLK); #1;

    // START pulse, then START+ABORT gives ABORT only
    axi_write(7'h10, 32'h1, 4'hF, rsp);
    repeat (3) @(posedge ACLK); #1;
    check("start_cnt", start_cnt, 1);
    axi_write(7'h10, 32'h3, 4'hF, rsp);
    repeat (3) @(posedge ACLK); #1;
    check("abort_cnt", abort_cnt, 1); check("start_cnt_after_both", start_cnt, 1);

    // Busy protection
    miner_busy = 1;
    axi_write(7'h00, 32'h55, 4'hF, rsp); check("busy_wr00_resp", rsp, 2'b10);
    check("busy_nonce_start", nonce_start, 32'h1);
    axi_write(7'h0C, 32'h77, 4'hF, rsp); check("busy_scratch_resp", rsp, 0);
    axi_write(7'h10, 32'h1, 4'hF, rsp); check("busy_start_resp", rsp, 0);
    repeat (2) @(posedge ACLK); #1;
    check("busy_start_dropped", start_cnt, 1);

    // Found / done sticky status
    found_nonce_in = 32'h1234_5678; miner_found = 1;
    @(posedge ACLK); #1 miner_found = 0;
    axi_read(7'h14, rd, rsp); check("status_found", rd, 32'h3);
    axi_read(7'h18, rd, rsp); check("found_nonce", rd, 32'h1234_5678);
    // W1C found in the same cycle as a second found pulse
    AWADDR = 7'h14; AWVALID = 1; WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1; BREADY = 1;
    found_nonce_in = 32'h9ABC_DEF0; miner_found = 1;
    @(posedge ACLK); #1 AWVALID = 0; WVALID = 0; miner_found = 0;
    @(posedge ACLK); #1;
    axi_read(7'h14, rd, rsp); check("status_set_wins", rd, 32'h3);
    axi_read(7'h18, rd, rsp); check("found_nonce2", rd, 32'h9ABC_DEF0);
    axi_write(7'h14, 32'h2, 4'hF, rsp);
    axi_read(7'h14, rd, rsp); check("status_w1c", rd, 32'h1);
    miner_done = 1; @(posedge ACLK); #1 miner_done = 0;
    axi_read(7'h14, rd, rsp); check("status_done", rd, 32'h5);
    axi_write(7'h14, 32'h4, 4'h0, rsp);
    axi_read(7'h14, rd, rsp); check("w1c_nostrb", rd, 32'h5);

    // Unmapped / read-only
    axi_read(7'h7C, rd, rsp); check("unmapped_rdata", rd, 0); check("unmapped_rresp", rsp, 2'b10);
    axi_write(7'h18, 32'hFFFF_FFFF, 4'hF, rsp); check("ro_bresp", rsp, 2'b10);
    axi_read(7'h18, rd, rsp); check("ro_unchanged", rd, 32'h9ABC_DEF0);

    // Reset while a write response is pending
    miner_busy = 0;
    AWADDR = 7'h04; AWVALID = 1; WDATA = 32'hAA; WSTRB = 4'hF; WVALID = 1; BREADY = 0;
    @(posedge ACLK); #1 AWVALID = 0; WVALID = 0;
    @(negedge ACLK); check("pend_bvalid", {31'd0, BVALID}, 1);
    #2 ARESETN = 0;
    #1 check("rst_drops_b", {31'd0, BVALID}, 0);
    @(posedge ACLK); #1 ARESETN = 1; BREADY = 1;
    repeat (2) @(posedge ACLK); #1;
    check("no_b_after_rst", {31'd0, BVALID}, 0);
    axi_read(7'h00, rd, rsp); check("rst_rd00", rd, 0);
    axi_read(7'h04, rd, rsp); check("rst_rd04", rd, 0);
    axi_read(7'h0C, rd, rsp); check("rst_rd0c", rd, 0);
    axi_read(7'h14, rd, rsp); check("rst_status", rd, 0);
    axi_read(7'h20, rd, rsp); check("rst_midstate", rd, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
